// File: rtl/prog_mem_loader.sv
// Boot loader: parses A5/LEN/data/CSUM byte frames into 32-bit program-memory writes.
// Registered outputs; in_ready is always 1, so bytes are never back-pressured.
module prog_mem_loader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 2048,
  parameter int TIMEOUT    = 65535,
  parameter int BOOT_HOLD  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int ADDR_WORDS = 1 << (ADDR_WIDTH - 2);
  localparam int MAXW       = (MEM_DEPTH < ADDR_WORDS) ? MEM_DEPTH : ADDR_WORDS;
  localparam int TW         = $clog2(TIMEOUT + 1);

  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [16:0]   MAXW_L     = 17'(MAXW);
  localparam logic          BOOT_RST_N = (BOOT_HOLD == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           word_idx_q, word_idx_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           word_q, word_d;
  logic [7:0]            sum_q, sum_d;
  logic [TW-1:0]         idle_q, idle_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  cpu_rst_n_q, cpu_rst_n_d;

  logic        accept;
  logic        in_frame;
  logic [15:0] len_new;

  assign in_ready = 1'b1;
  assign accept   = in_valid && in_ready;
  assign in_frame = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
  assign len_new  = {in_data, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_idx_d  = word_idx_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    sum_d       = sum_q;
    idle_d      = idle_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    cpu_rst_n_d = cpu_rst_n_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (accept && in_data == 8'hA5) begin
          state_d    = S_LEN_LO;
          sum_d      = 8'h00;
          word_idx_d = 16'h0000;
          byte_cnt_d = 2'd0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d   = {len_q[15:8], in_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = len_new;
          if ({1'b0, len_new} > MAXW_L) begin
            state_d = S_ERROR;
          end else if (len_new == 16'h0000) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          sum_d      = sum_q + in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {word_q[15:0], in_data};
          // First byte of a word ends up in the MSBs once four bytes are shifted in.
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = ADDR_WIDTH'({word_idx_q, 2'b00});
            wr_data_d  = DATA_WIDTH'({word_q, in_data});
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == 16'(len_q - 16'd1)) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Inter-byte watchdog: only runs while a frame is open.
    if (!in_frame) begin
      idle_d = '0;
    end else if (accept) begin
      idle_d = '0;
    end else if (idle_q == TO_LAST) begin
      state_d = S_ERROR;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    busy_d  = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
              (state_d == S_DATA)   || (state_d == S_CSUM);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
    if (state_d == S_DONE) begin
      cpu_rst_n_d = 1'b1;
    end else if (state_d == S_IDLE) begin
      cpu_rst_n_d = BOOT_RST_N;
    end else begin
      cpu_rst_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= 16'h0000;
      word_idx_q  <= 16'h0000;
      byte_cnt_q  <= 2'd0;
      word_q      <= 24'h000000;
      sum_q       <= 8'h00;
      idle_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= BOOT_RST_N;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      sum_q       <= sum_d;
      idle_q      <= idle_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cpu_rst_n = cpu_rst_n_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: frame-position reference model checked every cycle, plus literal checks.
module tb_prog_mem_loader;
  localparam int TO   = 16;
  localparam int MAXW = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wr_en, cpu_rst_n, busy, done, error;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;

  prog_mem_loader #(
    .ADDR_WIDTH(11), .DATA_WIDTH(32), .MEM_DEPTH(2048), .TIMEOUT(TO), .BOOT_HOLD(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position of the byte within the current frame decides its meaning.
  bit          m_active;
  int          m_pos, m_n, m_idle, m_res;  // m_res: 0 none, 1 done, 2 error
  logic [7:0]  m_sum, m_nlo;
  logic [31:0] m_word;
  bit          m_wr;
  int          m_wr_addr;
  logic [31:0] m_wr_data;

  always @(posedge clk or negedge rst_n) begin
    int k;
    if (!rst_n) begin
      m_active = 0; m_pos = 0; m_n = 0; m_idle = 0; m_res = 0;
      m_sum = 0; m_nlo = 0; m_word = 0; m_wr = 0; m_wr_addr = 0; m_wr_data = 0;
    end else begin
      m_wr = 0;
      if (m_active) begin
        if (in_valid) begin
          m_idle = 0;
          m_pos++;
          k = m_pos - 3;
          if (m_pos == 1) begin
            m_nlo = in_data;
          end else if (m_pos == 2) begin
            m_n = int'({in_data, m_nlo});
            if (m_n > MAXW) begin m_active = 0; m_res = 2; end
          end else if (k < 4 * m_n) begin
            m_sum  = m_sum + in_data;
            m_word = {m_word[23:0], in_data};
            if (k % 4 == 3) begin
              m_wr = 1; m_wr_addr = (k / 4) * 4; m_wr_data = m_word;
            end
          end else begin
            m_active = 0;
            m_res = (in_data == m_sum) ? 1 : 2;
          end
        end else begin
          m_idle++;
          if (m_idle == TO) begin m_active = 0; m_res = 2; end
        end
      end else if (in_valid && in_data == 8'hA5) begin
        m_active = 1; m_pos = 0; m_sum = 0; m_idle = 0; m_res = 0; m_word = 0;
      end
    end
  end

  int          pulses = 0;
  logic [10:0] last_addr = '0;
  logic [31:0] mem [0:511];

  always @(negedge clk) begin
    logic [5:0] exp_ctrl;
    exp_ctrl = {1'b1, m_active, (m_res == 1) && !m_active, (m_res == 2) && !m_active,
                (m_res == 1) && !m_active, m_wr};
    check("ctrl{rdy,busy,done,err,cpu,wr}", {in_ready, busy, done, error, cpu_rst_n, wr_en}, exp_ctrl);
    if (m_wr) begin
      check("wr_addr", wr_addr, m_wr_addr);
      check("wr_data", wr_data, m_wr_data);
    end
    if (wr_en) begin
      pulses++;
      mem[wr_addr[10:2]] = wr_data;
      last_addr = wr_addr;
    end
  end

  logic [7:0] fb[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) begin in_valid = 1'b0; cyc(); end
    in_valid = 1'b1;
    in_data  = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input int csum_adj, input int maxgap);
    logic [7:0]  s;
    logic [15:0] nn;
    s  = 8'h00;
    nn = 16'(n);
    send(8'hA5, maxgap);
    send(nn[7:0], maxgap);
    send(nn[15:8], maxgap);
    for (int i = 0; i < 4 * n; i++) begin
      s = s + fb[i];
      send(fb[i], maxgap);
    end
    send(8'(int'(s) + csum_adj), maxgap);
  endtask

  initial begin
    int base, k;
    #1;
    check("rst wr_en", wr_en, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst busy/done/err", {busy, done, error}, 3'b000);
    check("rst in_ready", in_ready, 1);
    check("rst cpu_rst_n", cpu_rst_n, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // Nominal load preceded by noise
    base = pulses;
    send(8'h00, 0); send(8'hFF, 0); send(8'h5A, 0);
    check("noise ignored busy", busy, 0);
    fb = {8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    send_frame(2, 0, 0);
    check("nominal pulses", pulses - base, 2);
    check("nominal word0", mem[0], 32'h13000000);
    check("nominal word1", mem[1], 32'h6F000000);
    check("nominal done/err/cpu", {done, error, cpu_rst_n}, 3'b101);

    // Bad checksum 0x81
    base = pulses;
    send_frame(2, -1, 0);
    check("badcsum pulses", pulses - base, 2);
    check("badcsum done/err/cpu", {done, error, cpu_rst_n}, 3'b010);

    // Good frame afterwards
    fb = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h93};
    send_frame(2, 0, 3);
    check("recover done/err", {done, error}, 2'b10);
    check("recover word0", mem[0], 32'hDEADBEEF);
    check("recover word1", mem[1], 32'h00000093);

    // N = 513 rejected right after LEN_HI
    base = pulses;
    send(8'hA5, 0); send(8'h01, 0); send(8'h02, 0);
    check("overlen err", {busy, error}, 2'b01);
    send(8'h11, 0); send(8'h22, 0);
    check("overlen pulses", pulses - base, 0);

    // N = 0
    base = pulses;
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    check("n0 done", {done, error, cpu_rst_n}, 3'b101);
    check("n0 pulses", pulses - base, 0);

    // N = 512, full memory
    base = pulses;
    fb.delete();
    for (int i = 0; i < 2048; i++) fb.push_back(8'($urandom));
    send_frame(512, 0, 0);
    cyc();
    check("n512 pulses", pulses - base, 512);
    check("n512 last addr", last_addr, 11'h7FC);
    check("n512 last word", mem[511], {fb[2044], fb[2045], fb[2046], fb[2047]});
    check("n512 done", done, 1);

    // Timeout after 2 data bytes
    base = pulses;
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h11, 0); send(8'h22, 0);
    for (k = 1; k <= 40; k++) begin
      cyc();
      if (error) break;
    end
    check("timeout cycles", k, TO);
    check("timeout pulses", pulses - base, 0);

    // Random gaps below the timeout reproduce the nominal result
    for (int r = 0; r < 2; r++) begin
      base = pulses;
      fb = {8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
      send_frame(2, 0, TO - 1);
      check("gaps pulses", pulses - base, 2);
      check("gaps word0", mem[0], 32'h13000000);
      check("gaps word1", mem[1], 32'h6F000000);
      check("gaps done", {done, error, cpu_rst_n}, 3'b101);
    end

    // Reset after 6 data bytes
    base = pulses;
    fb = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
    for (int i = 0; i < 6; i++) send(fb[i], 0);
    cyc();
    rst_n = 1'b0;
    #1;
    check("midrst outs", {wr_en, busy, done, error, cpu_rst_n}, 5'b00000);
    check("midrst addr/data", {wr_addr, wr_data}, 43'h0);
    check("midrst pulses", pulses - base, 1);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("midrst no partial", pulses - base, 1);
    fb = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(2, 0, 2);
    check("reload pulses", pulses - base, 3);
    check("reload word0", mem[0], 32'h01020304);
    check("reload word1", mem[1], 32'h05060708);
    check("reload done", done, 1);

    // Random frames, checked cycle by cycle against the model
    for (int r = 0; r < 8; r++) begin
      int n;
      n = int'($urandom_range(1, 8));
      fb.delete();
      for (int i = 0; i < 4 * n; i++) fb.push_back(8'($urandom));
      send(8'($urandom_range(0, 8'hA4)), 2);
      send_frame(n, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 255)) : 0,
                 int'($urandom_range(0, TO - 1)));
    end

    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Byte-stream boot loader that writes the 32-bit instruction image into program memory: it is the write side of the instruction-memory path, whose fetch side reads words combinationally by byte address. It parses a framed byte stream (start byte, word count, data, checksum), assembles bytes into words and issues single-cycle memory writes at word-aligned byte addresses. While a load is in progress it holds the core in reset, and it reports done or error.

## Interface
- ADDR_WIDTH, 11, byte-address width of the program-memory port.
- DATA_WIDTH, 32, word width; fixed at 32, other values unsupported.
- MEM_DEPTH, 2048, memory depth in words.
- TIMEOUT, 65535, maximum idle cycles between bytes inside a frame.
- BOOT_HOLD, 1, if 1 the core is held in reset from rst_n until the first successful load.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader can accept a byte.
- wr_en  out  1  program-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_WIDTH  byte address of the word, always a multiple of 4.
- wr_data  out  32  word to write.
- cpu_rst_n  out  1  active-low reset to the core.
- busy  out  1  frame in progress.
- done  out  1  last frame completed successfully; sticky.
- error  out  1  last frame failed; sticky.

## Operation
- Byte accepted when in_valid && in_ready. in_ready = 1 in every state.
- Frame format: 0xA5, then LEN_LO, then LEN_HI (N = 16-bit word count), then N*4 data bytes, then CSUM.
- CSUM is the 8-bit modulo-256 sum of all data bytes.
- MAXW = min(MEM_DEPTH, 2^(ADDR_WIDTH-2)).
- States:
  - IDLE: 0xA5 goes to LEN_LO, clears done/error, clears the sum, word index and byte counter. Other bytes are discarded.
  - LEN_LO: latches N[7:0], goes to LEN_HI.
  - LEN_HI: latches N[15:8]. If N > MAXW go to ERROR; if N == 0 go to CSUM; otherwise go to DATA.
  - DATA: byte k of each word (k = 0..3) goes to wr_data bits [31-8k:24-8k]; the first byte lands in the MSBs. Each byte is added to the sum. On byte 3: write word, increment word index; after word N-1 go to CSUM.
  - CSUM: byte == sum goes to DONE; a mismatch goes to ERROR.
  - DONE: done = 1. 0xA5 starts a new frame (LEN_LO); other bytes are ignored.
  - ERROR: error = 1. 0xA5 starts a new frame; other bytes are ignored.
- Timeout:
  - An idle counter runs in LEN_LO, LEN_HI, DATA and CSUM.
  - It is cleared on every accepted byte and on state entry.
  - When it reaches TIMEOUT with no byte, the loader goes to ERROR.
  - It is inactive in IDLE, DONE and ERROR.
- Words written before a checksum or timeout failure stay in memory; they are not rolled back.
- cpu_rst_n:
  - Low whenever busy.
  - Low in ERROR.
  - High in DONE.
  - In IDLE after reset: BOOT_HOLD = 1 gives low, BOOT_HOLD = 0 gives high.
- busy = state in {LEN_LO, LEN_HI, DATA, CSUM}.

## Timing
- Reset values: state IDLE, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, error 0, in_ready 1, cpu_rst_n = !BOOT_HOLD.
- All outputs are registered, except in_ready (constant 1).
- Write timing: wr_en pulses for exactly one cycle, the cycle after the 4th byte of a word is accepted. wr_addr = word_index*4 and wr_data are stable in that cycle.
- Back-to-back bytes every cycle are supported; a write overlaps acceptance of the next word's first byte.
- State transitions take effect the cycle after the triggering byte.
- done, error and cpu_rst_n update in the same cycle the state enters DONE or ERROR.
- busy and cpu_rst_n = 0 take effect the cycle after 0xA5 is accepted.
- Timeout: ERROR is entered on the cycle the idle count equals TIMEOUT, which is TIMEOUT cycles after the last accepted byte or state entry.
- rst_n asserted mid-frame: immediate return to reset values. A partially assembled word is discarded and never written.
- in_valid low mid-word: byte assembly holds and no write occurs; only the timeout counter advances.

## Test plan
- Nominal load: stream A5 02 00, then 13 00 00 00, then 6F 00 00 00, then 82. Expect a write 0x13000000 at address 0x000, a write 0x6F000000 at address 0x004, then done = 1 and cpu_rst_n rising; exactly 2 wr_en pulses.
- Bad checksum: same frame with CSUM 0x81. Expect 2 writes, then error = 1, done = 0, cpu_rst_n = 0. A following good frame gives done = 1 and error = 0.
- Length limits:
  - N = 0x0201 (513 > MAXW 512) gives ERROR right after LEN_HI, with no wr_en.
  - N = 0 with CSUM 00 gives DONE with no writes.
  - N = 512 gives a last wr_addr of 0x7FC.
- Timeout: with TIMEOUT = 16, stop after 2 data bytes. Expect error = 1 exactly 16 cycles after the last byte, and no write.
- Noise and gaps: bytes 00 FF 5A before A5 are ignored. Random in_valid gaps inside a frame, each shorter than TIMEOUT, give results identical to the nominal load.
- Reset mid-frame: assert rst_n low after 6 data bytes. Expect outputs at reset values, no write for the partial word, and a subsequent full frame that loads correctly from address 0.
